// File: rtl/stepper_mmio_responder.sv
// stepper_mmio_responder: MMIO step/dir/enable driver with one active and one pending move.
// Status word is a flat concatenation of registered state, readable at any time.
module stepper_mmio_responder #(
    parameter logic [15:0] MIN_HALF  = 16'd2,
    parameter int          DIR_SETUP = 4
) (
    input  logic        clock,
    input  logic        reset,
    input  logic        new_data,
    input  logic [31:0] data_in,
    output logic [31:0] data_out,
    output logic [5:0]  JA
);
    typedef enum logic [1:0] {IDLE, SETUP, STEP_HI, STEP_LO} state_t;
    localparam logic [15:0] SETUP_LOAD = 16'(DIR_SETUP - 1);

    state_t      state_q;
    logic [15:0] timer_q, half_q, pend_half_q;
    logic [13:0] rem_q, done_q, pend_n_q;
    logic        dir_q, step_q, busy_q, pend_valid_q, ovf_q, pend_dir_q;

    logic        cmd_abort, cmd_valid, tick, finish, start, queue, drop;
    logic [15:0] cmd_half_d, src_half_d;
    logic [13:0] src_n_d;
    logic        src_dir_d;

    assign cmd_abort  = new_data & data_in[30];
    assign cmd_valid  = new_data & ~data_in[30] & (data_in[29:16] != 14'd0);
    assign cmd_half_d = (data_in[15:0] < MIN_HALF) ? MIN_HALF : data_in[15:0];
    assign tick       = timer_q == 16'd0;
    assign finish     = (state_q == STEP_LO) & tick & (rem_q == 14'd0);
    // A finishing move hands over to the pending slot first, otherwise to a fresh strobe.
    assign start      = (cmd_valid & ~busy_q) | (finish & (pend_valid_q | cmd_valid));
    assign queue      = cmd_valid & busy_q & (finish ? pend_valid_q : ~pend_valid_q);
    assign drop       = cmd_valid & busy_q & ~finish & pend_valid_q;
    assign src_dir_d  = pend_valid_q ? pend_dir_q  : data_in[31];
    assign src_n_d    = pend_valid_q ? pend_n_q    : data_in[29:16];
    assign src_half_d = pend_valid_q ? pend_half_q : cmd_half_d;

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state_q      <= IDLE;
            timer_q      <= 16'd0;
            half_q       <= 16'd0;
            rem_q        <= 14'd0;
            done_q       <= 14'd0;
            dir_q        <= 1'b0;
            step_q       <= 1'b0;
            busy_q       <= 1'b0;
            pend_valid_q <= 1'b0;
            ovf_q        <= 1'b0;
            pend_dir_q   <= 1'b0;
            pend_n_q     <= 14'd0;
            pend_half_q  <= 16'd0;
        end else if (cmd_abort) begin
            state_q      <= IDLE;
            step_q       <= 1'b0;
            busy_q       <= 1'b0;
            rem_q        <= 14'd0;
            pend_valid_q <= 1'b0;
            ovf_q        <= 1'b0;
        end else begin
            if (start) begin
                state_q <= SETUP;
                busy_q  <= 1'b1;
                step_q  <= 1'b0;
                dir_q   <= src_dir_d;
                rem_q   <= src_n_d;
                done_q  <= 14'd0;
                half_q  <= src_half_d;
                timer_q <= SETUP_LOAD;
            end else begin
                case (state_q)
                    IDLE: ;
                    STEP_HI:
                        if (!tick) timer_q <= timer_q - 16'd1;
                        else begin
                            state_q <= STEP_LO;
                            step_q  <= 1'b0;
                            timer_q <= half_q - 16'd1;
                        end
                    default:
                        if (!tick) timer_q <= timer_q - 16'd1;
                        else if (state_q == SETUP || rem_q != 14'd0) begin
                            state_q <= STEP_HI;
                            step_q  <= 1'b1;
                            timer_q <= half_q - 16'd1;
                            rem_q   <= rem_q - 14'd1;
                            done_q  <= done_q + 14'd1;
                        end else begin
                            state_q <= IDLE;
                            busy_q  <= 1'b0;
                        end
                endcase
            end
            if (queue) begin
                pend_valid_q <= 1'b1;
                pend_dir_q   <= data_in[31];
                pend_n_q     <= data_in[29:16];
                pend_half_q  <= cmd_half_d;
            end else if (finish && pend_valid_q) begin
                pend_valid_q <= 1'b0;
            end
            if (drop) ovf_q <= 1'b1;
        end
    end

    assign data_out = {busy_q, pend_valid_q, ovf_q, dir_q, rem_q, done_q};
    assign JA       = {2'b00, busy_q, ~busy_q, dir_q, step_q};
endmodule

// File: tb/tb_stepper_mmio_responder.sv
// tb_stepper_mmio_responder: directed checks of timing, queueing, overflow, abort and reset.
module tb_stepper_mmio_responder;
    logic        clock = 1'b0;
    logic        reset = 1'b0;
    logic        new_data = 1'b0;
    logic [31:0] data_in = 32'd0;
    logic [31:0] data_out;
    logic [5:0]  JA;
    int errors = 0;
    int checks = 0;

    stepper_mmio_responder dut (
        .clock(clock), .reset(reset), .new_data(new_data),
        .data_in(data_in), .data_out(data_out), .JA(JA)
    );

    always #5 clock = ~clock;

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic strobe(input logic [31:0] w);
        new_data = 1'b1;
        data_in  = w;
        tick();
        new_data = 1'b0;
        data_in  = 32'd0;
    endtask

    task automatic wait_rise(output int n);
        n = 0;
        while (JA[0] !== 1'b1 && n < 200) begin
            tick();
            n++;
        end
    endtask

    // Enter with step high; leaves at the next rise or when busy drops.
    task automatic measure(output int h, output int l);
        h = 0;
        l = 0;
        while (JA[0] === 1'b1 && h < 200) begin
            tick();
            h++;
        end
        while (JA[0] === 1'b0 && JA[3] === 1'b1 && l < 200) begin
            tick();
            l++;
        end
    endtask

    task automatic test_reset();
        repeat (3) tick();
        checks++;
        if (JA !== 6'b000100) begin errors++; $display("FAIL reset_ja got=%b want=000100", JA); end
        checks++;
        if (data_out !== 32'd0) begin errors++; $display("FAIL reset_data got=%h want=0", data_out); end
        reset = 1'b1;
        tick();
        checks++;
        if (data_out !== 32'd0) begin errors++; $display("FAIL post_reset_data got=%h want=0", data_out); end
    endtask

    task automatic test_basic();
        int n, h, l;
        strobe(32'h8003_0005);
        checks++;
        if (data_out !== 32'h9000_C000) begin errors++; $display("FAIL basic_accept got=%h want=9000c000", data_out); end
        checks++;
        if (JA !== 6'b001010) begin errors++; $display("FAIL basic_ja got=%b want=001010", JA); end
        wait_rise(n);
        checks++;
        if (n + 1 !== 5) begin errors++; $display("FAIL basic_latency got=%0d want=5", n + 1); end
        checks++;
        if (data_out !== 32'h9000_8001) begin errors++; $display("FAIL basic_first_hi got=%h want=90008001", data_out); end
        for (int p = 0; p < 3; p++) begin
            measure(h, l);
            checks++;
            if (h !== 5 || l !== 5) begin errors++; $display("FAIL basic_pulse%0d got=%0d/%0d want=5/5", p, h, l); end
        end
        checks++;
        if (data_out !== 32'h1000_0003) begin errors++; $display("FAIL basic_done got=%h want=10000003", data_out); end
    endtask

    task automatic test_clamp();
        int n, h, l;
        strobe(32'h0002_0000);
        checks++;
        if (data_out !== 32'h8000_8000) begin errors++; $display("FAIL clamp_accept got=%h want=80008000", data_out); end
        wait_rise(n);
        checks++;
        if (n + 1 !== 5) begin errors++; $display("FAIL clamp_latency got=%0d want=5", n + 1); end
        for (int p = 0; p < 2; p++) begin
            measure(h, l);
            checks++;
            if (h !== 2 || l !== 2) begin errors++; $display("FAIL clamp_pulse%0d got=%0d/%0d want=2/2", p, h, l); end
        end
        checks++;
        if (data_out !== 32'h0000_0002) begin errors++; $display("FAIL clamp_done got=%h want=00000002", data_out); end
    endtask

    task automatic test_queue();
        int n, h, l;
        strobe(32'h8004_0003);
        strobe(32'h0002_0003);
        checks++;
        if (data_out !== 32'hD001_0000) begin errors++; $display("FAIL queue_pend got=%h want=d0010000", data_out); end
        wait_rise(n);
        for (int p = 0; p < 4; p++) begin
            measure(h, l);
            checks++;
            if (h !== 3 || l !== (p == 3 ? 7 : 3))
                begin errors++; $display("FAIL queue_pulse%0d got=%0d/%0d want=3/%0d", p, h, l, p == 3 ? 7 : 3); end
        end
        checks++;
        if (data_out !== 32'h8000_4001) begin errors++; $display("FAIL queue_second got=%h want=80004001", data_out); end
        checks++;
        if (JA !== 6'b001001) begin errors++; $display("FAIL queue_ja got=%b want=001001", JA); end
        for (int p = 0; p < 2; p++) begin
            measure(h, l);
            checks++;
            if (h !== 3 || l !== 3) begin errors++; $display("FAIL queue_b_pulse%0d got=%0d/%0d want=3/3", p, h, l); end
        end
        checks++;
        if (data_out !== 32'h0000_0002) begin errors++; $display("FAIL queue_done got=%h want=00000002", data_out); end
    endtask

    task automatic test_overflow();
        strobe(32'h8005_0004);
        strobe(32'h0003_0002);
        strobe(32'h0007_0002);
        checks++;
        if (data_out !== 32'hF001_4000) begin errors++; $display("FAIL ovf_set got=%h want=f0014000", data_out); end
        strobe(32'h4000_0000);
        checks++;
        if (data_out !== 32'h1000_0000) begin errors++; $display("FAIL ovf_abort got=%h want=10000000", data_out); end
        checks++;
        if (JA !== 6'b000110) begin errors++; $display("FAIL ovf_abort_ja got=%b want=000110", JA); end
    endtask

    task automatic test_coincidence();
        int n, h, l;
        strobe(32'h0001_0002);
        strobe(32'h8001_0002);
        repeat (6) tick();
        strobe(32'h0001_0002);
        checks++;
        if (data_out !== 32'hD000_4000) begin errors++; $display("FAIL coin_pend got=%h want=d0004000", data_out); end
        strobe(32'h8000_0007);
        checks++;
        if (data_out !== 32'hD000_4000) begin errors++; $display("FAIL zero_busy_data got=%h want=d0004000", data_out); end
        checks++;
        if (JA !== 6'b001010) begin errors++; $display("FAIL zero_busy_ja got=%b want=001010", JA); end
        strobe(32'h4000_0000);
        strobe(32'h0000_0005);
        checks++;
        if (data_out !== 32'h1000_0000) begin errors++; $display("FAIL zero_idle_data got=%h want=10000000", data_out); end
        checks++;
        if (JA !== 6'b000110) begin errors++; $display("FAIL zero_idle_ja got=%b want=000110", JA); end
        strobe(32'h0001_0002);
        repeat (7) tick();
        strobe(32'h8001_0003);
        checks++;
        if (data_out !== 32'h9000_4000) begin errors++; $display("FAIL coin_direct got=%h want=90004000", data_out); end
        wait_rise(n);
        measure(h, l);
        checks++;
        if (h !== 3 || l !== 3) begin errors++; $display("FAIL coin_direct_pulse got=%0d/%0d want=3/3", h, l); end
        checks++;
        if (data_out !== 32'h1000_0001) begin errors++; $display("FAIL coin_direct_done got=%h want=10000001", data_out); end
    endtask

    task automatic test_async_reset();
        int n;
        strobe(32'h8003_0005);
        wait_rise(n);
        checks++;
        if (JA[0] !== 1'b1) begin errors++; $display("FAIL areset_pre step=%b want=1", JA[0]); end
        #3;
        reset = 1'b0;
        #1;
        checks++;
        if (JA !== 6'b000100) begin errors++; $display("FAIL areset_ja got=%b want=000100", JA); end
        checks++;
        if (data_out !== 32'd0) begin errors++; $display("FAIL areset_data got=%h want=0", data_out); end
        tick();
        reset = 1'b1;
        tick();
        checks++;
        if (data_out !== 32'd0) begin errors++; $display("FAIL areset_after got=%h want=0", data_out); end
    endtask

    initial begin
        test_reset();
        test_basic();
        test_clamp();
        test_queue();
        test_overflow();
        test_coincidence();
        test_async_reset();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
